// File: rtl/song_reader.sv
// song_reader: steps through the {note, duration} entries of the selected
// song in a synchronous ROM. Each entry's duration is handed to the external
// beat timer and its note is presented to the note player until the timer
// reports expiry, then the next entry is fetched. A zero duration marks the
// end of a song; a song that fills every index ends after its last entry.
module song_reader #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int IDX_W  = 5,
   parameter int SONG_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic                     beat,
   input  logic [SONG_W-1:0]        song,
   output logic [SONG_W+IDX_W-1:0]  rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]  rom_data,
   output logic                     timer_clear,
   output logic                     timer_en,
   output logic [DUR_W-1:0]         duration_to_load,
   input  logic                     timer_done,
   output logic [NOTE_W-1:0]        note,
   output logic                     new_note,
   output logic                     song_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_PLAY,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   state_t             state;
   logic [SONG_W-1:0]  song_q;
   logic [IDX_W-1:0]   idx;
   logic [NOTE_W-1:0]  note_q;
   logic [DUR_W-1:0]   dur_q;
   logic               play_d;

   logic [NOTE_W-1:0]  rom_note;
   logic [DUR_W-1:0]   rom_dur;
   logic               play_rise;

   assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur   = rom_data[DUR_W-1:0];
   assign play_rise = play & ~play_d;

   // The ROM address is always the latched song plus the current entry index.
   assign rom_addr         = {song_q, idx};
   assign duration_to_load = dur_q;

   // The timer only advances while a note is playing and play is held high;
   // dropping play freezes the timer, the state and the note together.
   assign timer_en = (state == S_PLAY) & play & beat;

   // The note is audible from the load cycle until the entry is retired.
   always_comb begin
      note = '0;
      if (state == S_LOAD || state == S_PLAY || state == S_NEXT)
         note = note_q;
   end

   // Sequencer: fetch entry, check for the end marker, load the timer, play
   // until timer expiry, then advance or finish. Pulses last one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         song_q      <= '0;
         idx         <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         play_d      <= 1'b0;
         new_note    <= 1'b0;
         timer_clear <= 1'b1;
         song_done   <= 1'b0;
      end else begin
         play_d      <= play;
         new_note    <= 1'b0;
         timer_clear <= 1'b0;
         song_done   <= 1'b0;
         case (state)
            S_IDLE: begin
               // Only a fresh rising edge starts a song; a level held high
               // from the previous song does not retrigger it.
               if (play_rise) begin
                  song_q <= song;
                  idx    <= '0;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (rom_dur == '0) begin
                  song_done <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  note_q      <= rom_note;
                  dur_q       <= rom_dur;
                  new_note    <= 1'b1;
                  timer_clear <= 1'b1;
                  state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               state <= S_PLAY;
            end
            S_PLAY: begin
               if (timer_done)
                  state <= S_NEXT;
            end
            S_NEXT: begin
               // The index never wraps: a full song ends after its last slot.
               if (idx == LAST_IDX) begin
                  song_done <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: drives song_reader with a behavioural song ROM and beat
// timer. For every started song a timeline model predicts each new_note and
// song_done pulse (queued for the monitor) plus the per-cycle note, timer
// enable, timer clear and fetch address.
module tb_song_reader;
   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;
   localparam int IDX_W  = 5;
   localparam int SONG_W = 2;
   localparam int N_ENT  = 1 << IDX_W;
   localparam int MAXC   = 65536;

   typedef struct {
      bit done;
      int note;
      int dur;
      int cyc;
   } ev_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     play = 1'b0;
   logic                     beat = 1'b0;
   logic [SONG_W-1:0]        song = '0;
   logic [SONG_W+IDX_W-1:0]  rom_addr;
   logic [NOTE_W+DUR_W-1:0]  rom_data = '0;
   logic                     timer_clear;
   logic                     timer_en;
   logic [DUR_W-1:0]         duration_to_load;
   logic                     timer_done;
   logic [NOTE_W-1:0]        note;
   logic                     new_note;
   logic                     song_done;

   song_reader #(
      .NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)
   ) dut (
      .clk(clk), .reset(reset), .play(play), .beat(beat), .song(song),
      .rom_addr(rom_addr), .rom_data(rom_data), .timer_clear(timer_clear),
      .timer_en(timer_en), .duration_to_load(duration_to_load),
      .timer_done(timer_done), .note(note), .new_note(new_note),
      .song_done(song_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous song ROM.
   logic [NOTE_W+DUR_W-1:0] rom [0:(1<<(SONG_W+IDX_W))-1];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Beat timer: counts enabled beats, done on the beat that reaches the load.
   int tcnt = 0;
   always @(posedge clk) begin
      if (timer_clear) tcnt <= 0;
      else if (timer_en) tcnt <= tcnt + 1;
   end
   assign timer_done = timer_en && ((tcnt + 1) == int'(duration_to_load));

   // Stimulus configuration, interpreted per cycle.
   int g_s = MAXC, g_end = MAXC, g_pa = MAXC, g_pb = MAXC;
   int g_per = 1, g_ph = 0, g_rst = -1, g_chg = MAXC;
   int g_song = 0, g_song2 = 0;
   bit init_rst = 1'b1;

   function automatic bit play_at(input int c);
      return (c >= g_s) && (c < g_end) && !((c >= g_pa) && (c < g_pb));
   endfunction

   function automatic bit beat_at(input int c);
      return (c % g_per) == g_ph;
   endfunction

   always @(posedge clk) begin
      #1;
      beat  = beat_at(cyc);
      play  = play_at(cyc);
      reset = init_rst || (cyc == g_rst);
      song  = SONG_W'((cyc >= g_chg) ? g_song2 : g_song);
   end

   // Expectations.
   logic [NOTE_W-1:0]        e_note [MAXC];
   bit                       e_en   [MAXC];
   bit                       e_clr  [MAXC];
   bit                       e_fv   [MAXC];
   logic [SONG_W+IDX_W-1:0]  e_addr [MAXC];
   int w_lo = 0, w_hi = -1;
   ev_t evq[$];
   int  lq[$];
   bit  chk_on = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
      end
   endtask

   // Timeline of one song from the play-rise cycle s: fetch, wait, load,
   // play for d enabled beats, then 4 cycles to the next load or the end
   // marker's done; after the last index only 2 cycles to done.
   task automatic build_model(input int s, input int sng);
      int L, c, cnt, d, nt, i, done_c, base;
      for (int k = s; k < s + 3000 && k < MAXC; k++) begin
         e_note[k] = '0; e_en[k] = 1'b0; e_clr[k] = 1'b0; e_fv[k] = 1'b0;
      end
      lq.delete();
      base = sng * N_ENT;
      L = s + 3;
      i = 0;
      done_c = -1;
      while (done_c < 0) begin
         e_fv[L-2]   = 1'b1;
         e_addr[L-2] = (SONG_W+IDX_W)'(base + i);
         d  = int'(rom[base+i][DUR_W-1:0]);
         nt = int'(rom[base+i][NOTE_W+DUR_W-1:DUR_W]);
         if (d == 0) begin
            done_c = L;
         end else begin
            lq.push_back(L);
            evq.push_back('{done: 1'b0, note: nt, dur: d, cyc: L});
            e_clr[L] = 1'b1;
            c = L + 1;
            cnt = 0;
            while (c < s + 2900) begin
               if (play_at(c) && beat_at(c)) begin
                  e_en[c] = 1'b1;
                  cnt++;
                  if (cnt == d) break;
               end
               c++;
            end
            for (int k = L; k <= c + 1; k++) e_note[k] = NOTE_W'(nt);
            if (i == N_ENT - 1) done_c = c + 2;
            else begin
               L = c + 4;
               i++;
            end
         end
      end
      evq.push_back('{done: 1'b1, note: 0, dur: 0, cyc: done_c});
   endtask

   task automatic run_song(input int sng, input int per, input int ph,
                           input int pause_after, input int pause_len,
                           input int hold, input bit do_rst);
      int s, r, done_c;
      @(negedge clk);
      s = cyc + 1;
      g_per = per; g_ph = ph; g_s = s; g_end = MAXC;
      g_song = sng; g_song2 = sng; g_chg = MAXC; g_rst = -1;
      g_pa = MAXC; g_pb = MAXC;
      if (pause_len > 0) begin
         g_pa = s + 4 + pause_after;
         g_pb = g_pa + pause_len;
      end
      build_model(s, sng);
      done_c = evq[$].cyc;
      w_lo = s;
      w_hi = done_c + 1;
      if (do_rst) begin
         g_song2 = (sng + 2) % 4;
         g_chg   = lq[1] + 1;
         r       = lq[2] + 1;
         g_rst   = r;
         g_end   = r + 1;
         while (evq.size() > 0 && evq[$].cyc > r) evq.pop_back();
         w_hi = r + 1;
         e_note[r+1] = '0; e_en[r+1] = 1'b0; e_fv[r+1] = 1'b0; e_clr[r+1] = 1'b1;
         while (cyc < r + 1) @(negedge clk);
         chk("after_reset_rom_addr", int'(rom_addr), 0);
         chk("after_reset_timer_clear", int'(timer_clear), 1);
         chk("after_reset_timer_en", int'(timer_en), 0);
         chk("after_reset_duration", int'(duration_to_load), 0);
         chk("after_reset_note", int'(note), 0);
         chk("after_reset_new_note", int'(new_note), 0);
         chk("after_reset_song_done", int'(song_done), 0);
      end else begin
         g_end = done_c + 1 + hold;
      end
      while (cyc < g_end + 3) @(negedge clk);
      chk("events_left", evq.size(), 0);
      evq.delete();
   endtask

   task automatic set_entry(input int sng, input int i, input int nt, input int d);
      rom[sng*N_ENT+i] = {NOTE_W'(nt), DUR_W'(d)};
   endtask

   task automatic clear_song(input int sng);
      for (int i = 0; i < N_ENT; i++) rom[sng*N_ENT+i] = '0;
   endtask

   // Monitor: pops the expected pulse whenever the DUT pulses, and checks
   // the per-cycle outputs against the model.
   ev_t ev;
   always @(negedge clk) begin
      if (chk_on) begin
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            ev = evq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL event_missing: done=%0d note=%0d due at cycle %0d, not observed by cycle %0d",
                     ev.done, ev.note, ev.cyc, cyc);
         end
         if (new_note || song_done) begin
            if (evq.size() == 0) begin
               chk("unexpected_new_note", int'(new_note), 0);
               chk("unexpected_song_done", int'(song_done), 0);
            end else begin
               ev = evq.pop_front();
               chk("event_cycle", cyc, ev.cyc);
               chk("event_song_done", int'(song_done), int'(ev.done));
               chk("event_new_note", int'(new_note), int'(!ev.done));
               if (!ev.done) begin
                  chk("new_note_value", int'(note), ev.note);
                  chk("new_note_duration", int'(duration_to_load), ev.dur);
               end
            end
         end
         if (cyc >= w_lo && cyc <= w_hi) begin
            chk("note", int'(note), int'(e_note[cyc]));
            chk("timer_en", int'(timer_en), int'(e_en[cyc]));
            chk("timer_clear", int'(timer_clear), int'(e_clr[cyc]));
            if (e_fv[cyc]) chk("rom_addr", int'(rom_addr), int'(e_addr[cyc]));
         end else begin
            chk("idle_note", int'(note), 0);
            chk("idle_timer_en", int'(timer_en), 0);
            chk("idle_timer_clear", int'(timer_clear), 0);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sng, len, per;
      for (int k = 0; k < (1 << (SONG_W+IDX_W)); k++) rom[k] = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset_rom_addr", int'(rom_addr), 0);
      chk("reset_timer_clear", int'(timer_clear), 1);
      chk("reset_timer_en", int'(timer_en), 0);
      chk("reset_duration", int'(duration_to_load), 0);
      chk("reset_note", int'(note), 0);
      chk("reset_new_note", int'(new_note), 0);
      chk("reset_song_done", int'(song_done), 0);
      init_rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;

      // Three notes then an end marker, beat every cycle.
      set_entry(0, 0, 5, 2); set_entry(0, 1, 7, 1);
      set_entry(0, 2, 9, 3); set_entry(0, 3, 0, 0);
      run_song(0, 1, 0, 0, 0, 0, 1'b0);

      // Full song with no end marker: ends after the last index.
      for (int i = 0; i < N_ENT; i++) set_entry(2, i, $urandom_range(0, 63), 1);
      run_song(2, 1, 0, 0, 0, 0, 1'b0);

      // Pause for 10 cycles after 2 beats of a 6-beat note.
      clear_song(1);
      set_entry(1, 0, $urandom_range(1, 63), 6);
      set_entry(1, 1, $urandom_range(1, 63), 2);
      run_song(1, 1, 0, 2, 10, 0, 1'b0);

      // Beat every 4th cycle, every phase.
      clear_song(3);
      for (int i = 0; i < 3; i++) set_entry(3, i, $urandom_range(1, 63), 3);
      for (int ph = 0; ph < 4; ph++) run_song(3, 4, ph, 0, 0, 0, 1'b0);

      // Reset in the middle of a note with song changed while playing,
      // then a clean restart.
      clear_song(1);
      for (int i = 0; i < 4; i++) set_entry(1, i, $urandom_range(1, 63), 2);
      run_song(1, 1, 0, 0, 0, 0, 1'b1);
      run_song(1, 1, 0, 0, 0, 0, 1'b0);

      // Play held high well past the end: no restart until a new edge.
      run_song(0, 1, 0, 0, 0, 20, 1'b0);
      run_song(0, 1, 0, 0, 0, 0, 1'b0);

      // Random songs and beat spacing.
      for (int n = 0; n < 8; n++) begin
         sng = $urandom_range(0, 3);
         clear_song(sng);
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++)
            set_entry(sng, i, $urandom_range(0, 63), $urandom_range(1, 5));
         per = $urandom_range(1, 4);
         run_song(sng, per, $urandom_range(0, per - 1), 0, 0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/song_reader.md
# song_reader

Note sequencer for the music player. It reads {note, duration} entries for the selected song from a synchronous song ROM and drives the beat timer's control side (`timer_clear`, `en`, `duration_to_load`). It advances to the next note on the timer's `timer_done` and hands each note to the note player.

## Interface
- `NOTE_W`, default 6: note code width; note 0 = rest.
- `DUR_W`, default 6: duration width in beats; must match the timer's `duration_to_load`.
- `IDX_W`, default 5: note index width; songs hold up to 2^IDX_W entries.
- `SONG_W`, default 2: song select width.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `play`, input, 1: level. Its rising edge starts a song; low pauses playback.
- `beat`, input, 1: one-cycle beat tick.
- `song`, input, SONG_W: song select, sampled only at start.
- `rom_addr`, output, SONG_W+IDX_W: registered ROM address {song_q, idx}.
- `rom_data`, input, NOTE_W+DUR_W: {note, duration}, valid one cycle after `rom_addr`.
- `timer_clear`, output, 1: beat timer clear.
- `timer_en`, output, 1: beat timer enable.
- `duration_to_load`, output, DUR_W: current note duration, in beats.
- `timer_done`, input, 1: beat timer terminal pulse.
- `note`, output, NOTE_W: current note; 0 when not playing.
- `new_note`, output, 1: one-cycle pulse when `note` changes to a new entry.
- `song_done`, output, 1: one-cycle pulse at end of song.

## Operation
States and transitions:
- IDLE: goes to FETCH on a `play` rising edge (registered `play_d`). Latches `song_q <= song` and sets `idx <= 0`.
- FETCH: `rom_addr` = {song_q, idx}. Next state WAIT.
- WAIT: `rom_data` is valid. If duration == 0 (end marker), go to DONE. Otherwise latch `note_q`/`dur_q` and go to LOAD.
- LOAD: `new_note=1` and `timer_clear=1` for this cycle. Next state PLAY.
- PLAY: `timer_en = play & beat`. On `timer_done`, go to NEXT.
- NEXT: if `idx == 2^IDX_W-1`, go to DONE. Otherwise `idx <= idx+1` and go to FETCH.
- DONE: `song_done=1` for one cycle, `note <= 0`, then IDLE.

Output and datapath rules:
- `note` = `note_q` in LOAD, PLAY and NEXT; 0 in all other states.
- `duration_to_load` = `dur_q`, held stable from LOAD until the next latch.
- Pause: `play` low in PLAY blocks `timer_en`; state, `note` and timer count are held. `play` low in other states does not stall fetch. It only gates `timer_en`.
- `play` rising edges outside IDLE are ignored. `song` changes outside IDLE are ignored.
- Reset is checked first every cycle. It returns to IDLE, clears `idx`, `song_q`, `note_q`, `dur_q` and `play_d`, and silences the note immediately.

## Timing
- Reset values:
  - `rom_addr` = 0.
  - `timer_clear` = 1 during reset, 0 after.
  - `timer_en`, `duration_to_load`, `note`, `new_note`, `song_done` = 0.
- `play` rising edge sampled at edge E: FETCH in cycle E+1; `new_note` in cycle E+3; first possible `timer_en` in cycle E+4.
- A note of duration d with `beat` high every cycle: PLAY lasts exactly d cycles. Gap from `timer_done` to the next `new_note` is 4 cycles (NEXT, FETCH, WAIT, LOAD).
- `timer_done` is honoured only in PLAY; it is ignored in every other state.
- Duration 1 is legal: `timer_done` on the first enabled beat.
- Index wrap: after entry 2^IDX_W-1 completes, go to DONE. `idx` is not incremented past the last entry.

## Test plan
1. Song 0 = {(5,2), (7,1), (9,3), (x,0)}, `beat`=1, bench timer instantiated, one `play` pulse. Required:
   - `new_note` pulses with note 5, 7, 9.
   - `note` held for 2, 1 and 3 cycles of PLAY.
   - `song_done` 4 cycles after the last `timer_done`.
   - `note`=0 afterwards.
2. Song 2 with all 32 entries of duration 1 and no end marker. Required: exactly 32 `new_note` pulses, then `song_done`; `rom_addr` never exceeds {2,31}.
3. Pause mid-note: duration 6, drop `play` after 2 beats for 10 cycles, then raise it. Required: `timer_en`=0 while low, `note` unchanged, `timer_done` after 4 further beats.
4. Sparse `beat` (every 4th cycle), duration 3. Required: PLAY lasts 3 beats = 9–12 cycles, depending on beat phase at entry.
5. `reset` asserted in PLAY. Required:
   - Next cycle all outputs at reset values.
   - A later `play` edge restarts from `idx` 0.
   - `song` changed while in PLAY has no effect before restart.
6. `play` held high through `song_done`. Required: no restart until `play` falls and rises again.
